// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the riscv fetch stage: opcodes, NOP encoding, reset PC, buffer entry.
package riscv_fetch_pkg;

    // Major opcodes (instr[6:0]) of RV32I
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One fetched instruction together with its byte PC
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Instruction addresses must be word aligned
    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/riscv_fetch_buf.sv
// Two-entry instruction buffer: an output register backed by one skid entry, with flush.
module riscv_fetch_buf
    import riscv_fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         push_valid_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic         out_valid_o,
    output fetch_entry_t out_entry_o,
    output logic [1:0]   count_o
);

    logic         out_valid_q, out_valid_d;
    fetch_entry_t out_q, out_d;
    logic         skid_valid_q, skid_valid_d;
    fetch_entry_t skid_q, skid_d;

    // Next-state: flush wins; otherwise refill the output slot when it frees up, else park in skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || pop_i) begin
            if (skid_valid_q) begin
                // Older skid entry moves forward first to keep program order
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = push_valid_i;
                if (push_valid_i) begin
                    skid_d = push_entry_i;
                end
            end else begin
                out_valid_d = push_valid_i;
                if (push_valid_i) begin
                    out_d = push_entry_i;
                end
            end
        end else if (push_valid_i) begin
            skid_valid_d = 1'b1;
            skid_d       = push_entry_i;
        end
    end

    // Buffer state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_entry_o = out_q;
    assign count_o     = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: PC, imem read issue, in-flight tracking, redirect and fault handling.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc,
    output logic                  fault
);

    logic [31:0]  pc_q, pc_d;
    logic         infl_valid_q, infl_valid_d;
    logic [31:0]  infl_pc_q, infl_pc_d;
    logic         fault_q, fault_d;

    logic         buf_valid;
    fetch_entry_t buf_entry;
    fetch_entry_t resp_entry;
    logic [1:0]   buf_count;
    logic         pop;
    logic [2:0]   occ;
    logic         redir_ok;
    logic         redir_bad;
    logic         seq_issue;

    assign pop       = buf_valid & out_ready;
    // Instructions already owned by the stage after this cycle's pop; capped at buffer depth
    assign occ       = {1'b0, buf_count} + {2'b00, infl_valid_q} - {2'b00, pop};
    assign redir_ok  = redirect_valid & ~fault_q & is_aligned(redirect_pc);
    assign redir_bad = redirect_valid & ~is_aligned(redirect_pc);
    assign seq_issue = ~fault_q & ~redirect_valid & (occ < 3'd2);

    // Read strobe and address: a good redirect fetches its target in the same cycle
    always_comb begin
        imem_en   = 1'b0;
        imem_addr = pc_q[ADDR_WIDTH+1:2];
        if (redir_ok) begin
            imem_addr = redirect_pc[ADDR_WIDTH+1:2];
        end
        if (!reset) begin
            imem_en = redir_ok | seq_issue;
        end
    end

    // Next PC, in-flight tag and sticky fault
    always_comb begin
        pc_d         = pc_q;
        infl_valid_d = 1'b0;
        infl_pc_d    = infl_pc_q;
        fault_d      = fault_q | redir_bad;
        if (redir_ok) begin
            pc_d         = redirect_pc + 32'd4;
            infl_valid_d = 1'b1;
            infl_pc_d    = redirect_pc;
        end else if (seq_issue) begin
            pc_d         = pc_q + 32'd4;
            infl_valid_d = 1'b1;
            infl_pc_d    = pc_q;
        end
    end

    // Fetch control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            infl_valid_q <= 1'b0;
            infl_pc_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            infl_valid_q <= infl_valid_d;
            infl_pc_q    <= infl_pc_d;
            fault_q      <= fault_d;
        end
    end

    assign resp_entry = '{instr: imem_rdata, pc: infl_pc_q};

    // Any redirect (good or misaligned) flushes, which also drops the stale in-flight response
    riscv_fetch_buf u_buf (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (redirect_valid),
        .push_valid_i (infl_valid_q),
        .push_entry_i (resp_entry),
        .pop_i        (pop),
        .out_valid_o  (buf_valid),
        .out_entry_o  (buf_entry),
        .count_o      (buf_count)
    );

    assign out_valid = buf_valid;
    assign out_instr = buf_entry.instr;
    assign out_pc    = buf_entry.pc;
    assign fault     = fault_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// Self-checking bench for riscv_fetch: directed scenarios plus randomized traffic vs. a stream model.
module tb_riscv_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    logic [31:0] mem [0:1023];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;

    riscv_fetch #(
        .ADDR_WIDTH (10),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous program memory
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: every fetch issued since the last flush and not yet delivered, oldest first,
    // with the cycle it was issued; the head is visible two cycles after its issue.
    logic [31:0] q_pc [$];
    int          q_t [$];
    logic [31:0] m_next = 32'h0;
    bit          m_fault = 1'b0;
    bit          m_v, m_pop, m_en;
    logic [9:0]  m_addr;
    int          m_occ;

    always @(negedge clk) begin
        if (chk_en) begin
            m_v = (q_pc.size() > 0) && (q_t[0] + 2 <= cyc);
            check("out_valid", {31'b0, out_valid}, {31'b0, m_v});
            if (m_v) begin
                check("out_pc", out_pc, q_pc[0]);
                check("out_instr", out_instr, mem[q_pc[0][11:2]]);
            end
            check("fault", {31'b0, fault}, {31'b0, m_fault});
            m_pop  = m_v && out_ready;
            m_occ  = q_pc.size() - (m_pop ? 1 : 0);
            m_addr = m_next[11:2];
            if (reset || m_fault) begin
                m_en = 1'b0;
            end else if (redirect_valid) begin
                m_en   = (redirect_pc[1:0] == 2'b00);
                m_addr = redirect_pc[11:2];
            end else begin
                m_en = (m_occ < 2);
            end
            check("imem_en", {31'b0, imem_en}, {31'b0, m_en});
            if (m_en) check("imem_addr", {22'b0, imem_addr}, {22'b0, m_addr});
            // advance the model to the state after this clock edge
            if (reset) begin
                q_pc.delete();
                q_t.delete();
                m_fault = 1'b0;
                m_next  = 32'h0;
            end else begin
                if (m_pop) begin
                    void'(q_pc.pop_front());
                    void'(q_t.pop_front());
                end
                if (redirect_valid && !m_fault) begin
                    q_pc.delete();
                    q_t.delete();
                    if (redirect_pc[1:0] == 2'b00) begin
                        q_pc.push_back(redirect_pc);
                        q_t.push_back(cyc);
                        m_next = redirect_pc + 32'd4;
                    end else begin
                        m_fault = 1'b1;
                    end
                end else if (m_en) begin
                    q_pc.push_back(m_next);
                    q_t.push_back(cyc);
                    m_next = m_next + 32'd4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] tmp;
    logic [1:0]  lo;
    int          r;
    int          sel;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0]  = 32'h0001f0b7;
        mem[1]  = 32'h000f1137;
        mem[31] = 32'h00000067;

        // Scenario 1: reset values and first instructions at full rate
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("c0_imem_addr", {22'b0, imem_addr}, 32'd0);
        tick();
        @(negedge clk);
        check("c1_out_valid", {31'b0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("c2_out_valid", {31'b0, out_valid}, 32'd1);
        check("c2_instr", out_instr, 32'h0001f0b7);
        check("c2_pc", out_pc, 32'h0);
        tick();
        @(negedge clk);
        check("c3_instr", out_instr, 32'h000f1137);
        check("c3_pc", out_pc, 32'h4);
        tick();
        @(negedge clk);
        check("c4_pc", out_pc, 32'h8);
        tick();
        @(negedge clk);
        check("c5_pc", out_pc, 32'hc);

        // Scenario 2: decode stalls, then drains without gaps or repeats
        tick();
        out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        @(negedge clk);
        check("stall_pc", out_pc, 32'h0);
        check("stall_valid", {31'b0, out_valid}, 32'd1);
        check("stall_imem_en", {31'b0, imem_en}, 32'd0);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_valid", {31'b0, out_valid}, 32'd1);
            check("drain_pc", out_pc, 32'(4 * k));
            tick();
        end

        // Scenario 3: redirect with fetches in flight
        do_reset();
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7c;
        @(negedge clk);
        check("redir_imem_en", {31'b0, imem_en}, 32'd1);
        check("redir_imem_addr", {22'b0, imem_addr}, 32'd31);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_bubble", {31'b0, out_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("redir_valid", {31'b0, out_valid}, 32'd1);
        check("redir_instr", out_instr, 32'h00000067);
        check("redir_pc", out_pc, 32'h7c);

        // Scenario 4: misaligned redirect faults until reset
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h7e;
        @(negedge clk);
        check("mis_no_issue", {31'b0, imem_en}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("mis_fault", {31'b0, fault}, 32'd1);
        check("mis_valid", {31'b0, out_valid}, 32'd0);
        repeat (3) tick();
        @(negedge clk);
        check("mis_fault_sticky", {31'b0, fault}, 32'd1);
        check("mis_imem_en", {31'b0, imem_en}, 32'd0);
        tick();
        do_reset();
        @(negedge clk);
        check("mis_fault_clear", {31'b0, fault}, 32'd0);
        check("mis_restart_en", {31'b0, imem_en}, 32'd1);

        // Scenario 5: one-cycle reset mid-stream
        repeat (5) tick();
        reset = 1'b1;
        @(negedge clk);
        check("mid_valid_before", {31'b0, out_valid}, 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_valid_after", {31'b0, out_valid}, 32'd0);
        check("mid_refetch_addr", {22'b0, imem_addr}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        check("mid_first_pc", out_pc, 32'h0);
        check("mid_first_instr", out_instr, 32'h0001f0b7);

        // Scenario 6: imem address wraps while out_pc keeps counting
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffc;
        @(negedge clk);
        check("wrap_addr_hi", {22'b0, imem_addr}, 32'd1023);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr_lo", {22'b0, imem_addr}, 32'd0);
        tick();
        @(negedge clk);
        check("wrap_pc0", out_pc, 32'hffc);
        tick();
        @(negedge clk);
        check("wrap_pc1", out_pc, 32'h1000);
        check("wrap_instr1", out_instr, 32'h0001f0b7);

        // Randomized traffic: stalls, redirects (some misaligned, some near 32-bit wrap), resets
        for (int i = 0; i < 4000; i++) begin
            tick();
            out_ready      = ($urandom_range(0, 9) < 7);
            r              = $urandom_range(0, 99);
            reset          = (r < 2) || (fault && r < 30);
            redirect_valid = (r >= 2) && (r < 8);
            sel            = $urandom_range(0, 9);
            tmp            = $urandom;
            if (sel == 0) begin
                lo          = 2'($urandom_range(1, 3));
                redirect_pc = {tmp[31:2], lo};
            end else if (sel == 1) begin
                redirect_pc = 32'hffff_fff0 + 32'(4 * $urandom_range(0, 3));
            end else begin
                redirect_pc = {tmp[31:2], 2'b00};
            end
        end
        tick();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
